// File: rtl/tpic_readback_pkg.sv
// Shared definitions for the TPIC chain readback monitor.
//   state_t      : monitor FSM state encoding
//   ERR_CNT_MAX  : saturation value of the error event counter
//   clog2()      : bit width needed to hold values 0..value-1
package tpic_readback_pkg;

    // S_OFF is entered while monitoring is disabled.  It behaves exactly like
    // S_IDLE (no reference held) and falls into S_IDLE once enable returns.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_OFF   = 2'd2
    } state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tpic_readback_edge.sv
// edge_sync: registers an asynchronous-ish control line twice and flags its
// rising edge.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   sig   : raw input line
//   rise  : high for one clk when the registered line goes 0 -> 1
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig_q <= sig;
            sig_d <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_d;

endmodule

// File: rtl/tpic_readback.sv
// tpic_readback: captures the serial stream returned by a TPIC shift-register
// chain, frames it with the latch strobe and compares each complete frame
// with the memory vector that was being shifted out one frame earlier.
//   clk      : system clock (same clock as the TPIC driver)
//   reset    : asynchronous active-low reset
//   enable   : monitoring active
//   sclk     : TPIC shift clock as driven onto the chain
//   rck      : TPIC latch strobe
//   miso     : serial return from the end of the chain
//   data     : memory vector currently feeding the chain driver
//   clr_err  : one-cycle clear of mismatch, len_err and err_cnt
//   rb_data  : last complete captured frame (first bit received in MSB)
//   rb_valid : one-cycle pulse when rb_data and the compare result update
//   mismatch : sticky, a full frame differed from its reference
//   len_err  : sticky, a frame ended with the wrong bit count
//   err_cnt  : saturating count of mismatch and length error events
module tpic_readback
    import tpic_readback_pkg::*;
#(
    parameter int WIDTH = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sclk,
    input  logic             rck,
    input  logic             miso,
    input  logic [WIDTH-1:0] data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rb_data,
    output logic             rb_valid,
    output logic             mismatch,
    output logic             len_err,
    output logic [7:0]       err_cnt
);

    localparam int               CNT_W    = clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic             sclk_rise;
    logic             rck_rise;
    logic             miso_q;
    logic             miso_d;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cur_ref;
    logic [CNT_W-1:0] bit_cnt;
    state_t           state;

    logic frame_end;
    logic frame_full;
    logic cmp_fail;
    logic len_fail;
    logic any_fail;

    edge_sync u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (sclk),
        .rise  (sclk_rise)
    );

    edge_sync u_rck_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (rck),
        .rise  (rck_rise)
    );

    // miso gets the same two-stage delay as the edge detectors, so miso_d is
    // the value present while sclk_d was still low (before the chain shifted).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso_q <= 1'b0;
            miso_d <= 1'b0;
        end else begin
            miso_q <= miso;
            miso_d <= miso_q;
        end
    end

    // A frame is judged only when a reference is held (S_ARMED).
    assign frame_end  = enable && rck_rise && (state == S_ARMED);
    assign frame_full = (bit_cnt == CNT_FULL);
    assign cmp_fail   = frame_end && frame_full && (cap != ref_q);
    assign len_fail   = frame_end && !frame_full;
    assign any_fail   = cmp_fail || len_fail;

    // Capture, bit counting and state sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            cap     <= '0;
            ref_q   <= '0;
            cur_ref <= '0;
            rb_data <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (!enable) begin
                state   <= S_OFF;
                bit_cnt <= '0;
            end else if (rck_rise) begin
                // rck wins over a coincident sclk edge, which is dropped.
                bit_cnt <= '0;
                ref_q   <= cur_ref;
                state   <= S_ARMED;
                if (frame_end && frame_full) begin
                    rb_data  <= cap;
                    rb_valid <= 1'b1;
                end
            end else begin
                if (state == S_OFF) begin
                    state <= S_IDLE;
                end
                if (sclk_rise) begin
                    cap <= {cap[WIDTH-2:0], miso_d};
                    if (bit_cnt == '0) begin
                        cur_ref <= data;
                    end
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Sticky error status; a clear in the same cycle as a failure is applied
    // first so the new event survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch <= 1'b0;
            len_err  <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            mismatch <= (mismatch && !clr_err) || cmp_fail;
            len_err  <= (len_err && !clr_err) || len_fail;
            if (clr_err) begin
                err_cnt <= any_fail ? 8'd1 : 8'd0;
            end else if (any_fail && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tpic_readback.sv
// Self-checking bench for tpic_readback with WIDTH=8.  Frames are driven the
// way the chain driver would (sclk/rck/miso changing on the falling clk edge)
// and every frame result is checked against a frame-level reference model.
module tb_tpic_readback;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         sclk;
    logic         rck;
    logic         miso;
    logic [W-1:0] data;
    logic         clr_err;
    logic [W-1:0] rb_data;
    logic         rb_valid;
    logic         mismatch;
    logic         len_err;
    logic [7:0]   err_cnt;

    int n_cmp;
    int n_mis;

    // Frame-level reference model state
    bit           m_armed;
    logic [W-1:0] m_ref;
    logic [W-1:0] m_cur;
    logic [W-1:0] m_rb;
    bit           m_mis;
    bit           m_len;
    int           m_cnt;

    tpic_readback #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sclk     (sclk),
        .rck      (rck),
        .miso     (miso),
        .data     (data),
        .clr_err  (clr_err),
        .rb_data  (rb_data),
        .rb_valid (rb_valid),
        .mismatch (mismatch),
        .len_err  (len_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0;
        m_ref   = '0;
        m_cur   = '0;
        m_rb    = '0;
        m_mis   = 0;
        m_len   = 0;
        m_cnt   = 0;
    endtask

    // Shift n bits (bits[W-1] first); data changes after the first bit has
    // been taken, which must not disturb the snapshot.
    task automatic send_bits(input logic [W-1:0] bits, input int n, input logic [W-1:0] dval);
        data = dval;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sclk = 1'b0;
            miso = bits[W-1-i];
            if (i == 1) data = W'($urandom);
            @(negedge clk);
            @(negedge clk);
            sclk = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        sclk = 1'b0;
        miso = W'($urandom) & 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One frame: shift, optionally drop enable, then strobe rck and check.
    task automatic do_frame(input string tag, input logic [W-1:0] dval, input logic [W-1:0] bits,
                            input int n, input bit clr, input bit drop_en);
        bit exp_valid;
        send_bits(bits, n, dval);
        if (n > 0) m_cur = dval;
        if (drop_en) begin
            enable = 1'b0;
            m_armed = 0;
            repeat (3) @(negedge clk);
            enable = 1'b1;
            repeat (2) @(negedge clk);
        end
        exp_valid = 0;
        if (clr) begin
            m_mis = 0;
            m_len = 0;
            m_cnt = 0;
        end
        if (!m_armed) begin
            m_armed = 1;
        end else if (n == W) begin
            exp_valid = 1;
            m_rb = bits;
            if (bits != m_ref) begin
                m_mis = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end else begin
            m_len = 1;
            if (m_cnt < 255) m_cnt++;
        end
        m_ref = m_cur;

        @(negedge clk);
        rck = 1'b1;
        @(negedge clk);
        clr_err = clr;
        @(negedge clk);
        clr_err = 1'b0;
        chk({tag, ".rb_valid"}, 32'(rb_valid), 32'(exp_valid));
        chk({tag, ".rb_data"},  32'(rb_data),  32'(m_rb));
        chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
        chk({tag, ".len_err"},  32'(len_err),  32'(m_len));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(m_cnt));
        @(negedge clk);
        rck = 1'b0;
        chk({tag, ".pulse_end"}, 32'(rb_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".rb_data"},  32'(rb_data),  32'd0);
        chk({tag, ".rb_valid"}, 32'(rb_valid), 32'd0);
        chk({tag, ".mismatch"}, 32'(mismatch), 32'd0);
        chk({tag, ".len_err"},  32'(len_err),  32'd0);
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] b;
        int kind;
        int nb;
        bit c;

        n_cmp   = 0;
        n_mis   = 0;
        reset   = 1'b0;
        enable  = 1'b1;
        sclk    = 1'b0;
        rck     = 1'b0;
        miso    = 1'b0;
        data    = '0;
        clr_err = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: first frame only arms
        do_frame("s1_arm", 8'hA5, 8'h00, W, 0, 0);
        // Scenario 2: chain returns the previous frame A
        do_frame("s2_match", 8'h3C, 8'hA5, W, 0, 0);
        // Scenario 3: bit 0 flipped, then a clean frame keeps the sticky flag
        b = m_ref ^ 8'h01;
        do_frame("s3_flip", W'($urandom), b, W, 0, 0);
        do_frame("s3_clean", W'($urandom), m_ref, W, 0, 0);
        // Scenario 4: short frames, second one with a coincident clear
        do_frame("s4_short", W'($urandom), W'($urandom), W - 1, 0, 0);
        do_frame("s4_short_clr", W'($urandom), W'($urandom), W - 1, 1, 0);
        do_frame("s4_after", W'($urandom), m_ref, W, 0, 0);

        // Randomised mix of good, corrupted and short frames
        for (int i = 0; i < 40; i++) begin
            d    = W'($urandom);
            kind = $urandom_range(0, 2);
            c    = ($urandom_range(0, 3) == 0);
            nb   = W;
            if (kind == 0) begin
                b = m_ref;
            end else if (kind == 1) begin
                b = m_ref ^ W'($urandom_range(1, 255));
            end else begin
                b  = W'($urandom);
                nb = $urandom_range(1, W - 1);
            end
            do_frame("rand", d, b, nb, c, 0);
        end

        // Scenario 5: counter saturation
        for (int i = 0; i < 300; i++) begin
            do_frame("s5_sat", W'($urandom), m_ref ^ 8'h80, W, 0, 0);
        end
        chk("s5_final_cnt", 32'(err_cnt), 32'd255);

        // Scenario 6a: enable dropped mid-frame, the next rck only re-arms
        do_frame("s6_en_drop", W'($urandom), W'($urandom), 3, 0, 1);
        do_frame("s6_en_cmp", W'($urandom), m_ref, W, 0, 0);

        // Scenario 6b: asynchronous reset in the middle of a frame
        send_bits(W'($urandom), 3, W'($urandom));
        @(negedge clk);
        sclk = 1'b1;
        #5;
        reset = 1'b0;
        #1;
        check_all_zero("s6_async_rst");
        model_reset();
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        do_frame("s6_rst_arm", W'($urandom), W'($urandom), W, 0, 0);
        do_frame("s6_rst_cmp", W'($urandom), m_ref, W, 0, 0);
        do_frame("s6_rst_bad", W'($urandom), m_ref ^ 8'h10, W, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
